seg7_decode_mon: RTL and testbench
==================================

Name: seg7_decode_mon

Overview:
Receive-side counterpart of the hex up/down counter's 7-segment encoder. Samples an active-low 7-segment pattern bus and filters glitches by requiring a stable pattern. Decodes accepted patterns back to a 4-bit hex digit and infers counting direction from consecutive digits. Used on the board or bench to check that the displayed sequence matches legal up/down counting.

Parameters:
STABLE_CYC, 2, rising edges a new pattern must be seen unchanged before acceptance (>=1)
CNT_W, 8, width of the up/down step counters

Ports:
hit  in  1  clock; all logic on rising edge (counter side updates on falling edge)
reset  in  1  asynchronous, active-low reset
din  in  7  segment pattern, active-low, bit6..0 = g,f,e,d,c,b,a
clr  in  1  synchronous clear of step counters (and sticky flags, see Optional Feature)
dout  out  4  last legally decoded digit
valid  out  1  1 = last accepted pattern was legal
upd  out  1  one-cycle pulse on every accepted pattern change
dir  out  1  direction of last legal step; 1 = up, 0 = down
step_err  out  1  pulse: legal digit not +/-1 (mod 16) from previous legal digit
bad  out  1  pulse: accepted pattern is not one of the 16 legal codes
up_cnt  out  CNT_W  count of +1 steps
dn_cnt  out  CNT_W  count of -1 steps

Behaviour:
- Legal codes (digit:pattern): 0:1000000 1:1111001 2:0100100 3:0110000 4:0011001 5:0010010 6:0000010 7:1111000 8:0000000 9:0010000 A:0001000 B:0000011 C:1000110 D:0100001 E:0000110 F:0001110. All other patterns are illegal.
- Reset (async, reset=0): dout=0, valid=0, upd=0, dir=1, step_err=0, bad=0, up_cnt=dn_cnt=0. Internal sample and accepted pattern = 1111111 (blank). have_prev=0. Reset takes effect immediately, including mid-filter or mid-step.
- Filter: din is registered every edge. Let k be the first edge that registers a new value. If din is unchanged at edges k..k+STABLE_CYC-1, the pattern is accepted at edge k+STABLE_CYC, provided it differs from the currently accepted pattern. Any change inside that window restarts the window, so shorter glitches are ignored.
- On acceptance, upd=1 for exactly one cycle.
- Accepted legal pattern:
  - dout <= digit, valid <= 1.
  - If have_prev=0: set have_prev; no step classification.
  - If digit == prev+1 mod 16: dir <= 1, up_cnt++.
  - If digit == prev-1 mod 16: dir <= 0, dn_cnt++.
  - Otherwise: step_err pulses for one cycle; dir holds.
  - Wrap-around: F->0 counts as up; 0->F counts as down.
- Accepted illegal pattern: valid <= 0, dout holds, bad pulses for one cycle, have_prev cleared. The next legal digit is therefore not classified.
- Counters saturate at all-ones and do not wrap.
- clr=1 zeroes both counters; clr wins over a simultaneous increment. clr does not affect dout, valid, dir or have_prev.
- Pulses (upd, step_err, bad) are registered outputs and are never combinational.

Optional Feature:
SEG7_MON_STICKY_EN
- Defined: step_err and bad become sticky. They are set on the event and held until clr or reset. If clr and a new event fall in the same cycle, the flag is set.
- Undefined: both are one-cycle pulses as above.

Decomposition:
- Package seg7_pkg holds:
  - the 16 legal pattern constants, indexed by digit
  - the blank pattern 1111111
  - a 4-bit digit typedef
  - a 7-bit pattern typedef
- One combinational sub-module, seg7_inv: pattern in; {legal, digit} out. It is the exact inverse of the team's encoder table.
- The filter, step classification and counters stay in seg7_decode_mon.

Test Plan:
- Reset release, then din=1000000 held 4 cycles -> upd pulses once at the 2nd edge after first sample; dout=0, valid=1, counters 0, step_err=0.
- Up sweep 0..F then 0, each digit held 4 cycles -> up_cnt=16, dn_cnt=0, dir=1, no step_err, 17 upd pulses.
- Sequence 0,F,E, each held 4 cycles -> dn_cnt=2, dir=0; then 1111001 (1) for 1 cycle between 0000110 (E) samples -> no upd, nothing changes.
- din=1111111 held -> bad pulse, valid=0, dout=E holds; then 0100100 -> valid=1, dout=2, no count change, no step_err.
- Legal 2 then 7 (1111000) -> step_err pulse, counters unchanged, dir unchanged. Then clr asserted together with a +1 step -> counters read 0.
- reset asserted mid-window of a pending pattern -> all outputs return to reset values immediately; pattern not accepted until a full STABLE_CYC window after release. Repeat with SEG7_MON_STICKY_EN defined: step_err stays 1 until clr.

Source files
------------

// File: rtl/seg7_decode_mon_pkg.sv
// Shared types and constants for the 7-segment receive monitor.
// Segment patterns are active-low, bit6..0 = g,f,e,d,c,b,a.
package seg7_pkg;

    typedef logic [3:0] digit_t;
    typedef logic [6:0] pat_t;

    // All segments off; also the power-up value of the sampled/accepted pattern
    localparam pat_t SEG_BLANK = 7'b1111111;

    // Encoder table, indexed by digit
    localparam pat_t SEG_CODE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/seg7_decode_mon_if.sv
// Pattern input / decode result bundle for seg7_decode_mon.
// master = stimulus/observer side, slave = the monitor itself.
interface seg7_decode_mon_if
    import seg7_pkg::*;
#(
    parameter int CNT_W = 8
);
    pat_t             din;
    logic             clr;
    digit_t           dout;
    logic             valid;
    logic             upd;
    logic             dir;
    logic             step_err;
    logic             bad;
    logic [CNT_W-1:0] up_cnt;
    logic [CNT_W-1:0] dn_cnt;

    modport master (
        output din, clr,
        input  dout, valid, upd, dir, step_err, bad, up_cnt, dn_cnt
    );

    modport slave (
        input  din, clr,
        output dout, valid, upd, dir, step_err, bad, up_cnt, dn_cnt
    );
endinterface

// File: rtl/seg7_decode_mon_inv.sv
// Inverse of the 7-segment encoder: pattern -> {legal, digit}.
// Anything outside the 16 encoder codes is reported as not legal.
module seg7_inv
    import seg7_pkg::*;
(
    input  pat_t   pat_i,
    output logic   legal_o,
    output digit_t digit_o
);

    // Table search; codes are unique so at most one entry matches
    always_comb begin
        legal_o = 1'b0;
        digit_o = '0;
        for (int i = 0; i < 16; i++) begin
            if (pat_i == SEG_CODE[i]) begin
                legal_o = 1'b1;
                digit_o = digit_t'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_decode_mon.sv
// 7-segment receive monitor: glitch filter, pattern decode, up/down step
// classification and saturating step counters.
// Optional build macro SEG7_MON_STICKY_EN: step_err/bad hold until clr/reset.
module seg7_decode_mon
    import seg7_pkg::*;
#(
    parameter int STABLE_CYC = 2,
    parameter int CNT_W      = 8
) (
    input logic              hit,
    input logic              reset,
    seg7_decode_mon_if.slave bus
);

    localparam int SC_W = $clog2(STABLE_CYC + 1);
    localparam logic [SC_W-1:0] STAB_MAX = SC_W'(STABLE_CYC - 1);

    pat_t             samp_q, samp_d;
    logic [SC_W-1:0]  stab_q, stab_d;
    pat_t             acc_q, acc_d;
    digit_t           dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             upd_q, upd_d;
    logic             dir_q, dir_d;
    logic             serr_q, serr_d;
    logic             bad_q, bad_d;
    logic             have_prev_q, have_prev_d;
    logic [CNT_W-1:0] up_q, up_d;
    logic [CNT_W-1:0] dn_q, dn_d;

    logic             inv_legal;
    digit_t           inv_digit;
    logic             accept;
    logic             serr_ev, bad_ev, up_inc, dn_inc;
    digit_t           prev_plus, prev_minus;

    seg7_inv u_inv (
        .pat_i   (samp_q),
        .legal_o (inv_legal),
        .digit_o (inv_digit)
    );

    // Filter, decode, step classification and counter next-state
    always_comb begin
        samp_d      = bus.din;
        stab_d      = stab_q;
        acc_d       = acc_q;
        dout_d      = dout_q;
        valid_d     = valid_q;
        upd_d       = 1'b0;
        dir_d       = dir_q;
        have_prev_d = have_prev_q;
        serr_ev     = 1'b0;
        bad_ev      = 1'b0;
        up_inc      = 1'b0;
        dn_inc      = 1'b0;
        prev_plus   = dout_q + 4'd1;
        prev_minus  = dout_q - 4'd1;

        // Stability count of the registered sample; a new value restarts it
        if (bus.din != samp_q) begin
            stab_d = '0;
        end else if (stab_q != STAB_MAX) begin
            stab_d = stab_q + SC_W'(1);
        end

        // samp_q has been unchanged for a full window and is a new pattern
        accept = (stab_q == STAB_MAX) && (samp_q != acc_q);

        if (accept) begin
            acc_d = samp_q;
            upd_d = 1'b1;
            if (inv_legal) begin
                dout_d      = inv_digit;
                valid_d     = 1'b1;
                have_prev_d = 1'b1;
                if (have_prev_q) begin
                    if (inv_digit == prev_plus) begin
                        dir_d  = 1'b1;
                        up_inc = 1'b1;
                    end else if (inv_digit == prev_minus) begin
                        dir_d  = 1'b0;
                        dn_inc = 1'b1;
                    end else begin
                        serr_ev = 1'b1;
                    end
                end
            end else begin
                valid_d     = 1'b0;
                bad_ev      = 1'b1;
                have_prev_d = 1'b0;
            end
        end

        // Saturating counters; clr takes priority over an increment
        up_d = up_q;
        dn_d = dn_q;
        if (bus.clr) begin
            up_d = '0;
            dn_d = '0;
        end else begin
            if (up_inc && (up_q != '1)) up_d = up_q + CNT_W'(1);
            if (dn_inc && (dn_q != '1)) dn_d = dn_q + CNT_W'(1);
        end

`ifdef SEG7_MON_STICKY_EN
        // A new event in the clr cycle still leaves the flag set
        serr_d = serr_ev | (serr_q & ~bus.clr);
        bad_d  = bad_ev  | (bad_q  & ~bus.clr);
`else
        serr_d = serr_ev;
        bad_d  = bad_ev;
`endif
    end

    // State registers; reset returns everything to the blank/idle state at once
    always_ff @(posedge hit or negedge reset) begin
        if (!reset) begin
            samp_q      <= SEG_BLANK;
            stab_q      <= '0;
            acc_q       <= SEG_BLANK;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            upd_q       <= 1'b0;
            dir_q       <= 1'b1;
            serr_q      <= 1'b0;
            bad_q       <= 1'b0;
            have_prev_q <= 1'b0;
            up_q        <= '0;
            dn_q        <= '0;
        end else begin
            samp_q      <= samp_d;
            stab_q      <= stab_d;
            acc_q       <= acc_d;
            dout_q      <= dout_d;
            valid_q     <= valid_d;
            upd_q       <= upd_d;
            dir_q       <= dir_d;
            serr_q      <= serr_d;
            bad_q       <= bad_d;
            have_prev_q <= have_prev_d;
            up_q        <= up_d;
            dn_q        <= dn_d;
        end
    end

    assign bus.dout     = dout_q;
    assign bus.valid    = valid_q;
    assign bus.upd      = upd_q;
    assign bus.dir      = dir_q;
    assign bus.step_err = serr_q;
    assign bus.bad      = bad_q;
    assign bus.up_cnt   = up_q;
    assign bus.dn_cnt   = dn_q;

endmodule

// File: tb/tb_seg7_decode_mon.sv
// Testbench for seg7_decode_mon: step table + scoreboard of expected
// results popped on every upd pulse, plus hand-written reset sequence.
module tb_seg7_decode_mon;

    localparam int CNT_W = 8;
`ifdef SEG7_MON_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    localparam logic [6:0] CODES [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [6:0] BLANK = 7'b1111111;

    typedef struct {
        logic [6:0] din;
        int         hold;
        logic       clr;
        logic       exp_upd;
        logic [3:0] dout;
        logic       valid;
        logic       dir;
        logic       serr;
        logic       bad;
        int         up;
        int         dn;
    } step_t;

    typedef logic [23:0] obs_t;

    logic hit;
    logic reset;
    seg7_decode_mon_if #(.CNT_W(CNT_W)) bus ();

    seg7_decode_mon #(.STABLE_CYC(2), .CNT_W(CNT_W)) dut (
        .hit   (hit),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial hit = 1'b0;
    always #5 hit = ~hit;

    int   checks   = 0;
    int   failures = 0;
    int   upd_seen = 0;
    bit   mon_en   = 1'b0;
    bit   sserr    = 1'b0;
    bit   sbad     = 1'b0;
    obs_t sb [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic obs_t observed();
        return {bus.dout, bus.valid, bus.dir, bus.step_err, bus.bad, bus.up_cnt, bus.dn_cnt};
    endfunction

    function automatic step_t mk(input logic [6:0] p, input int hold, input int clr, input int upd,
                                 input int dout, input int valid, input int dir, input int serr,
                                 input int bad, input int up, input int dn);
        step_t s;
        s.din     = p;
        s.hold    = hold;
        s.clr     = 1'(clr);
        s.exp_upd = 1'(upd);
        s.dout    = 4'(dout);
        s.valid   = 1'(valid);
        s.dir     = 1'(dir);
        s.serr    = 1'(serr);
        s.bad     = 1'(bad);
        s.up      = up;
        s.dn      = dn;
        return s;
    endfunction

    // Scoreboard consumer: every upd pulse must match the oldest expectation
    always @(negedge hit) begin
        if (mon_en) begin
            if (bus.upd === 1'b1) begin
                upd_seen++;
                if (sb.size() == 0) begin
                    check("upd_unexpected", 32'd1, 32'd0);
                end else begin
                    check($sformatf("upd%0d", upd_seen), 32'(observed()), 32'(sb.pop_front()));
                end
            end
`ifndef SEG7_MON_STICKY_EN
            else begin
                check("pulse_idle", {30'd0, bus.step_err, bus.bad}, 32'd0);
            end
`endif
        end
    end

    // Drive one step; expectation queued before the pattern is presented
    task automatic apply_step(input step_t s);
        logic es, eb;
        if (s.clr) begin
            sserr = 1'b0;
            sbad  = 1'b0;
        end
        if (s.exp_upd) begin
            sserr = sserr | s.serr;
            sbad  = sbad | s.bad;
            es = STICKY ? sserr : s.serr;
            eb = STICKY ? sbad  : s.bad;
            sb.push_back({s.dout, s.valid, s.dir, es, eb, CNT_W'(s.up), CNT_W'(s.dn)});
        end
        bus.din = s.din;
        bus.clr = s.clr;
        repeat (s.hold) @(posedge hit);
        @(negedge hit);
        #1;
        check("pending", 32'(sb.size()), 32'd0);
        if (!s.exp_upd) begin
            es = STICKY ? sserr : 1'b0;
            eb = STICKY ? sbad  : 1'b0;
            check("flags_idle", {30'd0, bus.step_err, bus.bad}, {30'd0, es, eb});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        step_t tbl  [$];
        step_t tbl2 [$];
        step_t s;
        int    d;

        // Main sequence: first digit, up sweep with wrap, down steps, glitch,
        // illegal pattern, step error, clr against an increment
        tbl.push_back(mk(CODES[0], 4, 0, 1, 0, 1, 1, 0, 0, 0, 0));
        for (int i = 1; i <= 16; i++)
            tbl.push_back(mk(CODES[i % 16], 4, 0, 1, i % 16, 1, 1, 0, 0, i, 0));
        tbl.push_back(mk(CODES[15], 4, 0, 1, 15, 1, 0, 0, 0, 16, 1));
        tbl.push_back(mk(CODES[14], 4, 0, 1, 14, 1, 0, 0, 0, 16, 2));
        tbl.push_back(mk(CODES[1],  1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(CODES[14], 4, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(BLANK,     4, 0, 1, 14, 0, 0, 0, 1, 16, 2));
        tbl.push_back(mk(CODES[2],  4, 0, 1, 2, 1, 0, 0, 0, 16, 2));
        tbl.push_back(mk(CODES[7],  4, 0, 1, 7, 1, 0, 1, 0, 16, 2));
        tbl.push_back(mk(CODES[8],  3, 1, 1, 8, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(CODES[9],  4, 0, 1, 9, 1, 1, 0, 0, 1, 0));
        tbl.push_back(mk(CODES[8],  4, 0, 1, 8, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(CODES[8],  2, 1, 0, 0, 0, 0, 0, 0, 0, 0));

        // After the reset sequence (digit 3 accepted, counters 0, dir 1)
        tbl2.push_back(mk(CODES[9],  4, 0, 1, 9, 1, 1, 1, 0, 0, 0));
        tbl2.push_back(mk(CODES[10], 4, 0, 1, 10, 1, 1, 0, 0, 1, 0));
        tbl2.push_back(mk(CODES[10], 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl2.push_back(mk(CODES[12], 3, 1, 1, 12, 1, 1, 1, 0, 0, 0));
        tbl2.push_back(mk(CODES[12], 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl2.push_back(mk(CODES[13], 4, 0, 1, 13, 1, 1, 0, 0, 1, 0));

        bus.din = BLANK;
        bus.clr = 1'b0;
        reset   = 1'b1;
        #1 reset = 1'b0;
        repeat (2) @(posedge hit);
        @(negedge hit);
        #1;
        check("reset_state",
              32'({bus.dout, bus.valid, bus.upd, bus.dir, bus.step_err, bus.bad, bus.up_cnt, bus.dn_cnt}),
              32'({4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00}));
        mon_en = 1'b1;
        reset  = 1'b1;

        foreach (tbl[i]) apply_step(tbl[i]);

        // Long up run: up_cnt must stop at all-ones
        d = 8;
        for (int i = 1; i <= 300; i++) begin
            d = (d + 1) % 16;
            s = mk(CODES[d], 4, 0, 1, d, 1, 1, 0, 0, (i > 255) ? 255 : i, 0);
            apply_step(s);
        end

        // Reset in the middle of a pending window
        bus.din = CODES[3];
        bus.clr = 1'b0;
        @(posedge hit);
        #2 reset = 1'b0;
        #1;
        check("async_reset",
              32'({bus.dout, bus.valid, bus.upd, bus.dir, bus.step_err, bus.bad, bus.up_cnt, bus.dn_cnt}),
              32'({4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00}));
        @(posedge hit);
        @(negedge hit);
        #1;
        sserr = 1'b0;
        sbad  = 1'b0;
        sb.push_back({4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0});
        reset = 1'b1;
        @(posedge hit);
        @(negedge hit);
        #1 check("no_early_upd_1", {31'd0, bus.upd}, 32'd0);
        @(posedge hit);
        @(negedge hit);
        #1 check("no_early_upd_2", {31'd0, bus.upd}, 32'd0);
        @(posedge hit);
        @(negedge hit);
        #1 check("post_reset_accept", 32'(sb.size()), 32'd0);

        foreach (tbl2[i]) apply_step(tbl2[i]);

        repeat (3) @(posedge hit);
        @(negedge hit);
        #1 check("final_drain", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
